router_fsm: RTL and testbench
=============================

Name: router_fsm

Overview:
- Packet-level controller for the 1x3 router. It sits upstream of the three output FIFOs and alongside the input register/parity block.
- Decodes the 2-bit destination address in the header byte and sequences the header, payload and parity load.
- Stalls the source via busy while the target FIFO is full or not yet empty.
- Produces the lfd_state strobe that the FIFO uses to tag header bytes.

Parameters:
- ADDR_W, 2, width of destination address field (din[1:0]); value 3 is invalid.
- NUM_DEST, 3, number of output FIFOs; fixed at 3, other values unsupported.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous active-low reset.
- pkt_valid  input  1  source asserts for the header and all payload bytes; deasserts on the parity byte.
- din  input  2  din[1:0] of the current input byte; only sampled in DECODE_ADDRESS.
- fifo_full  input  1  full flag of the currently selected destination FIFO, muxed externally.
- fifo_empty_0, fifo_empty_1, fifo_empty_2  input  1 each  empty flags of the FIFOs.
- softrst_0, softrst_1, softrst_2  input  1 each  per-FIFO soft reset (read timeout).
- parity_done  input  1  register block has captured the parity byte.
- low_pkt_valid  input  1  register block saw pkt_valid fall while the FIFO was full.
- detect_add  output  1  high in DECODE_ADDRESS.
- lfd_state  output  1  high in LOAD_FIRST_DATA.
- ld_state  output  1  high in LOAD_DATA.
- laf_state  output  1  high in LOAD_AFTER_FULL.
- full_state  output  1  high in FIFO_FULL_STATE.
- write_enb_reg  output  1  high in LOAD_DATA, LOAD_PARITY and LOAD_AFTER_FULL.
- rst_int_reg  output  1  high in CHECK_PARITY_ERROR; clears the internal parity register.
- busy  output  1  stall to source; see Behaviour.

Behaviour:
- States (one-hot or binary, encoding free):
  - DA (DECODE_ADDRESS)
  - LFD (LOAD_FIRST_DATA)
  - LD (LOAD_DATA)
  - WTE (WAIT_TILL_EMPTY)
  - FFS (FIFO_FULL_STATE)
  - LAF (LOAD_AFTER_FULL)
  - LP (LOAD_PARITY)
  - CPE (CHECK_PARITY_ERROR)
- Reset (rst=0, async): state=DA and addr_q=0. Outputs: detect_add=1, all other outputs 0.
- Address latch: in DA, when pkt_valid=1 and din!=3, set addr_q<=din. addr_q holds its value in all other states.
- Transitions, evaluated each rising clk:
  - DA: pkt_valid and din!=3 and fifo_empty[din]=1 -> LFD. pkt_valid and din!=3 and fifo_empty[din]=0 -> WTE. Otherwise (including din=3) stay DA; the invalid packet is dropped and busy stays 0.
  - LFD -> LD unconditionally; exactly one cycle.
  - LD: fifo_full=1 -> FFS. Else pkt_valid=0 -> LP. Else stay.
  - FFS: fifo_full=0 -> LAF. Else stay.
  - LAF: parity_done=1 -> DA. Else low_pkt_valid=1 -> LP. Else -> LD.
  - LP -> CPE unconditionally.
  - CPE: fifo_full=1 -> FFS. Else -> DA.
  - WTE: fifo_empty[addr_q]=1 -> LFD. Else stay.
- Soft reset: softrst_[addr_q]=1 in any state other than DA forces next state DA. This overrides every other transition. softrst of a non-selected FIFO is ignored.
- Outputs are Moore, decoded from the current state only; no input-to-output combinational path.
- busy=1 in LFD, WTE, FFS, LAF, LP and CPE; busy=0 in DA and LD.
- Latency: header accepted in DA at edge N; lfd_state=1 during cycle N+1; ld_state=1 from N+2.
- A new packet is accepted only in DA. pkt_valid arriving while busy=1 is the source's violation; no recovery is required.

Optional Feature:
- Macro: ROUTER_FSM_BUSY_REG_EN.
- Defined: busy is a flop loaded with the decode of the next state. It has the same logical value as the combinational decode of the current state, but is glitch-free and aligned to the state register. Reset value 0.
- Undefined: busy is a combinational decode of the current state.
- All other outputs are identical in both builds.

Test Plan:
- Reset: hold rst=0 for 3 cycles -> detect_add=1, busy=0, all other outputs 0.
- Release rst, then send an addr=1 header with fifo_empty_1=1, 4 payload bytes, then pkt_valid=0 -> states DA, LFD, LD x4, LP, CPE, DA. write_enb_reg=1 for exactly 5 cycles (4 LD + LP); lfd_state=1 for 1 cycle; rst_int_reg=1 for 1 cycle.
- Addr=2 header with fifo_empty_2=0 for 5 cycles, then 1 -> stay WTE with busy=1 for those 5 cycles, then LFD. lfd_state pulses exactly once.
- In LD, raise fifo_full for 3 cycles with low_pkt_valid=0 and parity_done=0 -> FFS for 3 cycles with full_state=1 and busy=1, then LAF, then LD.
- In LD, assert softrst_0 while addr_q=0 -> DA the next cycle with detect_add=1. Repeat in LD with addr_q=0 and softrst_1=1 -> no state change.
- Header with din=3 and pkt_valid=1 -> remain in DA, busy=0, write_enb_reg=0. Run both with and without ROUTER_FSM_BUSY_REG_EN and compare busy cycle by cycle.

Source files
------------

// File: rtl/router_fsm.sv
// rtl/router_fsm.sv - 1x3 router packet controller: address decode, header/payload/parity sequencing, busy stall.
// Define ROUTER_FSM_BUSY_REG_EN to register busy from the next-state decode instead of decoding it combinationally.
module router_fsm #(
    parameter int ADDR_W   = 2,
    parameter int NUM_DEST = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] din,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              softrst_0,
    input  logic              softrst_1,
    input  logic              softrst_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg,
    output logic              busy
);

    typedef enum logic [2:0] {
        DA  = 3'd0,
        LFD = 3'd1,
        LD  = 3'd2,
        WTE = 3'd3,
        FFS = 3'd4,
        LAF = 3'd5,
        LP  = 3'd6,
        CPE = 3'd7
    } state_t;

    state_t              state;
    state_t              next_state;
    logic [ADDR_W-1:0]   addr_q;
    logic [NUM_DEST-1:0] empty_vec;
    logic [NUM_DEST-1:0] softrst_vec;
    logic                din_ok;
    logic                din_empty;
    logic                sel_empty;
    logic                sel_softrst;

    assign empty_vec   = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign softrst_vec = {softrst_2, softrst_1, softrst_0};
    assign din_ok      = (din != {ADDR_W{1'b1}});

    function automatic logic busy_of(input state_t s);
        return (s == LFD) || (s == WTE) || (s == FFS) ||
               (s == LAF) || (s == LP)  || (s == CPE);
    endfunction

    // Address 3 has no FIFO, so both selectors fall to 0 for it.
    always_comb begin
        din_empty = 1'b0;
        case (din)
            2'd0:    din_empty = empty_vec[0];
            2'd1:    din_empty = empty_vec[1];
            2'd2:    din_empty = empty_vec[2];
            default: din_empty = 1'b0;
        endcase
    end

    always_comb begin
        sel_empty   = 1'b0;
        sel_softrst = 1'b0;
        case (addr_q)
            2'd0: begin
                sel_empty   = empty_vec[0];
                sel_softrst = softrst_vec[0];
            end
            2'd1: begin
                sel_empty   = empty_vec[1];
                sel_softrst = softrst_vec[1];
            end
            2'd2: begin
                sel_empty   = empty_vec[2];
                sel_softrst = softrst_vec[2];
            end
            default: begin
                sel_empty   = 1'b0;
                sel_softrst = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= DA;
            addr_q <= '0;
        end else begin
            state <= next_state;
            if (state == DA && pkt_valid && din_ok)
                addr_q <= din;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            DA: begin
                if (pkt_valid && din_ok)
                    next_state = din_empty ? LFD : WTE;
            end
            LFD: next_state = LD;
            LD: begin
                if (fifo_full)
                    next_state = FFS;
                else if (!pkt_valid)
                    next_state = LP;
            end
            FFS: begin
                if (!fifo_full)
                    next_state = LAF;
            end
            LAF: begin
                if (parity_done)
                    next_state = DA;
                else if (low_pkt_valid)
                    next_state = LP;
                else
                    next_state = LD;
            end
            LP:  next_state = CPE;
            CPE: next_state = fifo_full ? FFS : DA;
            WTE: begin
                if (sel_empty)
                    next_state = LFD;
            end
            default: next_state = DA;
        endcase
        // A read timeout on the selected FIFO abandons the packet from anywhere but DA.
        if (state != DA && sel_softrst)
            next_state = DA;
    end

    assign detect_add    = (state == DA);
    assign lfd_state     = (state == LFD);
    assign ld_state      = (state == LD);
    assign laf_state     = (state == LAF);
    assign full_state    = (state == FFS);
    assign write_enb_reg = (state == LD) || (state == LP) || (state == LAF);
    assign rst_int_reg   = (state == CPE);

`ifdef ROUTER_FSM_BUSY_REG_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            busy <= 1'b0;
        else
            busy <= busy_of(next_state);
    end
`else
    assign busy = busy_of(state);
`endif

endmodule

// File: tb/tb_router_fsm.sv
// tb/tb_router_fsm.sv - directed self-checking bench for router_fsm.
module tb_router_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       pkt_valid;
    logic [1:0] din;
    logic       fifo_full;
    logic [2:0] fe;
    logic [2:0] sr;
    logic       parity_done;
    logic       low_pkt_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg, busy;
    logic [7:0] outs;

    int tests = 0;
    int fails = 0;

    // {detect_add, lfd, ld, laf, full, write_enb, rst_int, busy}
    localparam logic [7:0] V_DA  = 8'b1000_0000;
    localparam logic [7:0] V_LFD = 8'b0100_0001;
    localparam logic [7:0] V_LD  = 8'b0010_0100;
    localparam logic [7:0] V_WTE = 8'b0000_0001;
    localparam logic [7:0] V_FFS = 8'b0000_1001;
    localparam logic [7:0] V_LAF = 8'b0001_0101;
    localparam logic [7:0] V_LP  = 8'b0000_0101;
    localparam logic [7:0] V_CPE = 8'b0000_0011;

    assign outs = {detect_add, lfd_state, ld_state, laf_state, full_state,
                   write_enb_reg, rst_int_reg, busy};

    always #5 clk = ~clk;

    router_fsm dut (
        .clk           (clk),
        .rst           (rst),
        .pkt_valid     (pkt_valid),
        .din           (din),
        .fifo_full     (fifo_full),
        .fifo_empty_0  (fe[0]),
        .fifo_empty_1  (fe[1]),
        .fifo_empty_2  (fe[2]),
        .softrst_0     (sr[0]),
        .softrst_1     (sr[1]),
        .softrst_2     (sr[2]),
        .parity_done   (parity_done),
        .low_pkt_valid (low_pkt_valid),
        .detect_add    (detect_add),
        .lfd_state     (lfd_state),
        .ld_state      (ld_state),
        .laf_state     (laf_state),
        .full_state    (full_state),
        .write_enb_reg (write_enb_reg),
        .rst_int_reg   (rst_int_reg),
        .busy          (busy)
    );

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++;
            if (outs !== V_DA) begin
                fails++;
                $display("FAIL reset cyc%0d: got %b want %b", i, outs, V_DA);
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] exp [8] = '{V_LFD, V_LD, V_LD, V_LD, V_LD, V_LP, V_CPE, V_DA};
        bit         pv  [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        int web_cnt = 0, lfd_cnt = 0, ri_cnt = 0;
        @(negedge clk);
        fe = 3'b010; pkt_valid = 1'b1; din = 2'd1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tests++;
            if (outs !== exp[i]) begin
                fails++;
                $display("FAIL basic step%0d: got %b want %b", i, outs, exp[i]);
            end
            web_cnt += int'(write_enb_reg);
            lfd_cnt += int'(lfd_state);
            ri_cnt  += int'(rst_int_reg);
            pkt_valid = pv[i];
            din = 2'd0;
        end
        tests++;
        if (web_cnt !== 5) begin
            fails++;
            $display("FAIL basic web_cnt: got %0d want 5", web_cnt);
        end
        tests++;
        if (lfd_cnt !== 1 || ri_cnt !== 1) begin
            fails++;
            $display("FAIL basic pulses: lfd %0d rst_int %0d want 1 1", lfd_cnt, ri_cnt);
        end
    endtask

    task automatic test_wait_empty();
        logic [7:0] exp [10] = '{V_WTE, V_WTE, V_WTE, V_WTE, V_WTE, V_LFD, V_LD, V_LP, V_CPE, V_DA};
        int lfd_cnt = 0;
        @(negedge clk);
        fe = 3'b000; pkt_valid = 1'b1; din = 2'd2;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            tests++;
            if (outs !== exp[i]) begin
                fails++;
                $display("FAIL wte step%0d: got %b want %b", i, outs, exp[i]);
            end
            lfd_cnt += int'(lfd_state);
            din = 2'd0;
            if (i == 4) fe = 3'b100;
            if (i == 6) pkt_valid = 1'b0;
        end
        tests++;
        if (lfd_cnt !== 1) begin
            fails++;
            $display("FAIL wte lfd_cnt: got %0d want 1", lfd_cnt);
        end
    endtask

    task automatic test_full_softrst();
        logic [7:0] exp [9] = '{V_LFD, V_LD, V_FFS, V_FFS, V_FFS, V_LAF, V_LD, V_LD, V_DA};
        @(negedge clk);
        fe = 3'b001; pkt_valid = 1'b1; din = 2'd0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tests++;
            if (outs !== exp[i]) begin
                fails++;
                $display("FAIL full step%0d: got %b want %b", i, outs, exp[i]);
            end
            case (i)
                1: fifo_full = 1'b1;
                4: fifo_full = 1'b0;
                6: sr = 3'b010;
                7: sr = 3'b001;
                default: ;
            endcase
        end
        sr = 3'b000; pkt_valid = 1'b0;
    endtask

    task automatic test_laf_exits();
        logic [7:0] exp [9] = '{V_LFD, V_LD, V_FFS, V_LAF, V_LP, V_CPE, V_FFS, V_LAF, V_DA};
        @(negedge clk);
        fe = 3'b001; pkt_valid = 1'b1; din = 2'd0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            tests++;
            if (outs !== exp[i]) begin
                fails++;
                $display("FAIL laf step%0d: got %b want %b", i, outs, exp[i]);
            end
            case (i)
                1: fifo_full = 1'b1;
                2: fifo_full = 1'b0;
                3: begin low_pkt_valid = 1'b1; pkt_valid = 1'b0; end
                4: begin low_pkt_valid = 1'b0; fifo_full = 1'b1; end
                6: fifo_full = 1'b0;
                7: parity_done = 1'b1;
                default: ;
            endcase
        end
        parity_done = 1'b0;
    endtask

    task automatic test_invalid_and_da_softrst();
        logic [7:0] exp [6] = '{V_DA, V_DA, V_DA, V_LFD, V_LD, V_DA};
        @(negedge clk);
        fe = 3'b111; pkt_valid = 1'b1; din = 2'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests++;
            if (outs !== exp[i]) begin
                fails++;
                $display("FAIL inv step%0d: got %b want %b", i, outs, exp[i]);
            end
            case (i)
                2: begin din = 2'd1; sr = 3'b001; end
                4: sr = 3'b010;
                default: ;
            endcase
        end
        sr = 3'b000; pkt_valid = 1'b0; din = 2'd0;
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        fe = 3'b001; pkt_valid = 1'b1; din = 2'd0;
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (outs !== V_LD) begin
            fails++;
            $display("FAIL async pre: got %b want %b", outs, V_LD);
        end
        #2 rst = 1'b0;
        #1;
        tests++;
        if (outs !== V_DA) begin
            fails++;
            $display("FAIL async reset: got %b want %b", outs, V_DA);
        end
        pkt_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0; pkt_valid = 1'b0; din = 2'd0; fifo_full = 1'b0;
        fe = 3'b000; sr = 3'b000; parity_done = 1'b0; low_pkt_valid = 1'b0;
        test_reset();
        test_basic();
        test_wait_empty();
        test_full_softrst();
        test_laf_exits();
        test_invalid_and_da_softrst();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
